// File: rtl/wire_ops_collect_if.sv
// Handshake bundle for wire_ops_collect: upstream beat channel and downstream head channel.
interface wire_ops_collect_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/wire_ops_collect.sv
// Collects op-result beats into a small FIFO; tracks XOR checksum and count of popped beats.
module wire_ops_collect #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     clear,
  wire_ops_collect_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         csum,
  output logic [15:0]              pop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] csum_q, csum_d;
  logic [15:0]      pop_cnt_q, pop_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic in_ready_w;
  logic out_valid_w;
  logic push;
  logic pop;

  assign in_ready_w  = (count_q < DEPTH_C) && !clear;
  assign out_valid_w = (count_q != '0) && !clear;
  assign push        = bus.in_valid && in_ready_w;
  assign pop         = out_valid_w && bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign count         = count_q;
  assign csum          = csum_q;
  assign pop_cnt       = pop_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    csum_d    = csum_q;
    pop_cnt_d = pop_cnt_q;
    mem_d     = mem_q;

    // push and pop are already gated by clear, so only the flush itself needs priority here
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      csum_d    = '0;
      pop_cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.in_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        csum_d    = csum_q ^ mem_q[rd_ptr_q];
        pop_cnt_d = pop_cnt_q + 16'd1;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      csum_q    <= '0;
      pop_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      csum_q    <= csum_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  // storage carries no reset; out_valid hides any slot not yet written
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_wire_ops_collect.sv
// Self-checking bench for wire_ops_collect against a queue-based reference model.
module tb_wire_ops_collect;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic        sys_clk;
  logic        sys_rst;
  logic        clear;
  logic [2:0]  count;
  logic [7:0]  csum;
  logic [15:0] pop_cnt;

  wire_ops_collect_if #(.WIDTH(WIDTH)) bus ();

  wire_ops_collect #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (clear),
    .bus     (bus),
    .count   (count),
    .csum    (csum),
    .pop_cnt (pop_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mq[$];
  logic [7:0]  m_csum;
  logic [15:0] m_pop;

  task automatic model_flush();
    mq.delete();
    m_csum = 8'h00;
    m_pop  = 16'h0000;
  endtask

  // drive one cycle's inputs, advance past the edge, and update the model from its own handshake prediction
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic exp_push, exp_pop;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    clear         = c;
    exp_push = v && (mq.size() < DEPTH) && !c;
    exp_pop  = r && (mq.size() != 0) && !c;
    @(posedge sys_clk);
    #1;
    if (c) begin
      model_flush();
    end else begin
      if (exp_pop) begin
        m_csum = m_csum ^ mq[0];
        m_pop  = m_pop + 16'd1;
        void'(mq.pop_front());
      end
      if (exp_push) mq.push_back(d);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0; clear = 1'b0;
    sys_rst = 1'b1;
    #12;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (csum !== 8'h00) begin miscompares++; $display("FAIL reset_csum got %h want 00", csum); end
    vectors++; if (pop_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_pop_cnt got %h want 0000", pop_cnt); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_flush();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_fill();
    logic [7:0] beats [4];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    for (int i = 0; i < 4; i++) step(1'b1, beats[i], 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d want 4", count); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_data !== 8'h11) begin miscompares++; $display("FAIL fill_head got %h want 11", bus.out_data); end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_overflow_count got %0d want 4", count); end
    vectors++; if (bus.out_data !== 8'h11) begin miscompares++; $display("FAIL fill_overflow_head got %h want 11", bus.out_data); end
  endtask

  task automatic test_drain();
    logic [7:0] want [4];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want[i]) begin
        miscompares++;
        $display("FAIL drain_beat%0d got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, want[i]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    bus.out_ready = 1'b0;
    vectors++; if (csum !== 8'h44) begin miscompares++; $display("FAIL drain_csum got %h want 44", csum); end
    vectors++; if (pop_cnt !== 16'd4) begin miscompares++; $display("FAIL drain_pop_cnt got %0d want 4", pop_cnt); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_count got %0d want 0", count); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    bus.in_valid = 1'b1; bus.in_data = 8'd0; bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_no_bypass got %b want 0", bus.out_valid); end
    step(1'b1, 8'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      want = 8'(i - 1);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want || count !== 3'd1) begin
        miscompares++;
        $display("FAIL b2b_beat%0d got v=%b d=%h cnt=%0d want v=1 d=%h cnt=1", i - 1, bus.out_valid, bus.out_data, count, want);
      end
      step(i < 10, 8'(i), 1'b1, 1'b0);
    end
    vectors++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end got cnt=%0d v=%b want cnt=0 v=0", count, bus.out_valid); end
    vectors++; if (pop_cnt !== m_pop || csum !== m_csum) begin miscompares++; $display("FAIL b2b_totals got pc=%0d cs=%h want pc=%0d cs=%h", pop_cnt, csum, m_pop, m_csum); end
  endtask

  task automatic test_clear();
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b1, 8'h69, 1'b0, 1'b0);
    step(1'b1, 8'h96, 1'b0, 1'b0);
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL clear_setup_count got %0d want 3", count); end
    bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.out_ready = 1'b1; clear = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL clear_gates got rdy=%b v=%b want 0 0", bus.in_ready, bus.out_valid); end
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0 || csum !== 8'h00 || pop_cnt !== 16'h0000) begin
      miscompares++;
      $display("FAIL clear_state got cnt=%0d cs=%h pc=%h want 0 00 0000", count, csum, pop_cnt);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++; if (count !== 3'd2 || csum !== 8'h12) begin miscompares++; $display("FAIL arst_setup got cnt=%0d cs=%h want 2 12", count, csum); end
    #2;
    sys_rst = 1'b1;
    #1;
    vectors++;
    if (count !== 3'd0 || csum !== 8'h00 || pop_cnt !== 16'h0000 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_immediate got cnt=%0d cs=%h pc=%h v=%b rdy=%b", count, csum, pop_cnt, bus.out_valid, bus.in_ready);
    end
    #1;
    sys_rst = 1'b0;
    model_flush();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL arst_first_push got v=%b d=%h cnt=%0d want 1 a5 1", bus.out_valid, bus.out_data, count);
    end
  endtask

  task automatic test_random();
    logic       v, r, c;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 29) == 0);
      d = 8'($urandom);
      step(v, d, r, c);
      vectors++;
      if (count !== 3'(mq.size()) || csum !== m_csum || pop_cnt !== m_pop ||
          bus.in_ready !== ((mq.size() < DEPTH) && !clear) ||
          bus.out_valid !== ((mq.size() != 0) && !clear) ||
          (mq.size() != 0 && bus.out_data !== mq[0])) begin
        miscompares++;
        $display("FAIL random_cycle%0d got cnt=%0d cs=%h pc=%0d rdy=%b v=%b d=%h want cnt=%0d cs=%h pc=%0d",
                 i, count, csum, pop_cnt, bus.in_ready, bus.out_valid, bus.out_data, mq.size(), m_csum, m_pop);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    clear = 1'b0;
  endtask

  task automatic test_pop_cnt_wrap();
    int budget;
    budget = 0;
    while (m_pop != 16'hFFFF && budget < 70000) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      budget++;
    end
    vectors++; if (m_pop != 16'hFFFF) begin miscompares++; $display("FAIL wrap_budget got %0d pops want 65535", m_pop); end
    vectors++; if (pop_cnt !== 16'hFFFF || csum !== m_csum) begin miscompares++; $display("FAIL wrap_preload got pc=%h cs=%h want ffff %h", pop_cnt, csum, m_csum); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL wrap_occupancy got %0d want 1", count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    vectors++; if (pop_cnt !== 16'h0000 || csum !== m_csum) begin miscompares++; $display("FAIL wrap_rollover got pc=%h cs=%h want 0000 %h", pop_cnt, csum, m_csum); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    test_pop_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wire_ops_collect.md
WIRE_OPS_COLLECT -- requirements
Module: wire_ops_collect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of each beat.
REQ-002 The block SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 clear  input  1  synchronous flush of FIFO, checksum and beat counter.
REQ-006 in_valid  input  1  upstream beat present (driven from the registered op-result stage).
REQ-007 in_data  input  WIDTH  upstream beat (op-result register output).
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 out_valid  output  1  head entry available downstream.
REQ-010 out_data  output  WIDTH  head entry value.
REQ-011 out_ready  input  1  downstream accepts head this cycle.
REQ-012 count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 csum  output  WIDTH  running XOR of all popped beats since reset/clear.
REQ-014 pop_cnt  output  16  number of popped beats since reset/clear, wraps modulo 2^16.

Function
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (count < DEPTH) && !clear, depending on no other input.
REQ-017 out_valid SHALL equal (count != 0) && !clear; out_data SHALL be the oldest stored entry, driven directly from storage (no extra register stage).
REQ-018 Latency SHALL be exactly 1 cycle: a beat pushed at edge N is visible on out_valid/out_data after edge N; no same-cycle bypass when empty.
REQ-019 Data SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and be legal at any occupancy 1..DEPTH-1; when full, push is blocked by in_ready=0 even if a pop occurs that cycle.
REQ-021 count SHALL increment on push-only, decrement on pop-only, hold otherwise; it SHALL never exceed DEPTH nor underflow.
REQ-022 On each pop, csum SHALL become csum ^ out_data and pop_cnt SHALL become pop_cnt+1 (16-bit wrap, 0xFFFF -> 0x0000).
REQ-023 When clear=1 at an edge: pointers, count, csum and pop_cnt SHALL become 0; no push or pop SHALL occur that cycle; clear has priority over all other activity.
REQ-024 in_data SHALL be sampled only on push; in_data and out_ready values are don't-care when not part of a handshake.
REQ-025 Storage contents SHALL NOT need a reset value; no output may expose unwritten storage (out_valid gates it).

Reset
REQ-026 While sys_rst=1, pointers, count, csum and pop_cnt SHALL be 0 immediately (asynchronously), hence in_ready=1 (if clear=0), out_valid=0.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered beats; the first push after deassertion SHALL behave as into an empty FIFO.
REQ-028 Deassertion SHALL be accepted on any edge; the first push may occur on the first rising edge with sys_rst=0.

Verification
REQ-029 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0, out_data=0x11; fifth beat 0x55 not accepted.
REQ-030 From full, out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44 in order, csum=0x44 (0x11^0x22^0x33^0x44), pop_cnt=4, count=0.
REQ-031 Continuous in_valid/out_ready=1 with data 0..9 from empty -> out_valid rises one cycle after first push, count stays 1, all 10 beats out in order, pointers wrap twice.
REQ-032 Preload pop_cnt to 0xFFFF by 65535 pops, one more pop -> pop_cnt=0x0000.
REQ-033 Count=3, assert clear with in_valid=1 and out_ready=1 -> next cycle count=0, csum=0, pop_cnt=0, no beat accepted or emitted.
REQ-034 Count=2, assert sys_rst between edges -> count, csum, pop_cnt read 0 before next edge; after release push 0xA5 -> out_data=0xA5 next cycle.
